// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU systolic datapath.
// Holds the PE element width, the default array height and the feeder FSM/slot types.
package tpu_pkg;

    localparam int unsigned PE_DATA_WIDTH = 16;
    localparam int unsigned DEFAULT_ROWS  = 4;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} feeder_state_t;

    typedef struct packed {
        logic signed [PE_DATA_WIDTH-1:0] data;
        logic                            valid;
        logic                            switch;
    } feeder_slot_t;

    function automatic feeder_slot_t beat_slot(input logic [PE_DATA_WIDTH-1:0] data,
                                               input logic                     sw);
        feeder_slot_t slot;
        slot.data   = data;
        slot.valid  = 1'b1;
        slot.switch = sw;
        return slot;
    endfunction

endpackage

// File: rtl/systolic_input_feeder_if.sv
// Valid/ready input stream carrying one ROWS-wide vector per beat into the feeder.
interface systolic_input_feeder_if #(
    parameter int unsigned ROWS       = tpu_pkg::DEFAULT_ROWS,
    parameter int unsigned DATA_WIDTH = tpu_pkg::PE_DATA_WIDTH
);
    logic                       valid;
    logic                       ready;
    logic [ROWS*DATA_WIDTH-1:0] data;
    logic                       switch;
    logic                       last;

    modport master (output valid, data, switch, last, input ready);
    modport slave  (input valid, data, switch, last, output ready);
endinterface

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register of feeder slots; DEPTH = 0 is a plain wire.
module skew_delay_line
    import tpu_pkg::*;
#(
    parameter int unsigned DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  feeder_slot_t slot_in,
    output feeder_slot_t slot_out
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, flush};
        assign slot_out    = slot_in;
    end else begin : g_shift
        feeder_slot_t stage_q [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else if (flush) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= slot_in;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign slot_out = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_input_feeder.sv
// West-edge feeder for a systolic PE array: skews each input vector diagonally across rows
// and tracks batch boundaries, pulsing done when the last beat has entered the bottom row.
module systolic_input_feeder
    import tpu_pkg::*;
#(
    parameter int unsigned ROWS       = DEFAULT_ROWS,
    parameter int unsigned DATA_WIDTH = PE_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    systolic_input_feeder_if.slave     s,
    output logic [ROWS*DATA_WIDTH-1:0] row_input,
    output logic [ROWS-1:0]            row_valid,
    output logic [ROWS-1:0]            row_switch,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                beat_count
);

    localparam int unsigned CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    feeder_state_t    state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [15:0]      beat_count_q, beat_count_d;
    logic             done_q, done_d;
    logic             busy_q;
    logic             accept;

    assign s.ready = (state_q != DRAIN) && !flush;
    assign accept  = s.valid && s.ready;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        feeder_slot_t entry, delayed, out_q;

        // Non-accepted cycles inject an all-zero bubble so stale data never reaches a PE.
        always_comb begin
            entry = '0;
            if (accept) entry = beat_slot(s.data[r*DATA_WIDTH +: DATA_WIDTH], s.switch);
        end

        skew_delay_line #(
            .DEPTH (r)
        ) u_delay (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .slot_in  (entry),
            .slot_out (delayed)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst)        out_q <= '0;
            else if (flush) out_q <= '0;
            else            out_q <= delayed;
        end

        assign row_input[r*DATA_WIDTH +: DATA_WIDTH] = out_q.data;
        assign row_valid[r]                          = out_q.valid;
        assign row_switch[r]                         = out_q.switch;
    end

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        beat_count_d = beat_count_q;
        done_d       = 1'b0;
        if (flush) begin
            state_d      = IDLE;
            drain_cnt_d  = '0;
            beat_count_d = '0;
        end else begin
            if (accept) begin
                if (state_q == IDLE)              beat_count_d = 16'd1;
                else if (beat_count_q != 16'hFFFF) beat_count_d = beat_count_q + 16'd1;
            end
            case (state_q)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (!s.last) begin
                            state_d = STREAM;
                        end else if (ROWS > 1) begin
                            state_d     = DRAIN;
                            drain_cnt_d = CNT_W'(ROWS - 1);
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Leaving at count 1 lands done in the cycle row ROWS-1 shows the last beat.
                    drain_cnt_d = drain_cnt_q - CNT_W'(1);
                    if (drain_cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            drain_cnt_q  <= '0;
            beat_count_q <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            beat_count_q <= beat_count_d;
            done_q       <= done_d;
            busy_q       <= (state_d != IDLE);
        end
    end

    assign done       = done_q;
    assign busy       = busy_q;
    assign beat_count = beat_count_q;

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Directed bench for systolic_input_feeder with ROWS=4: skew timing, bubbles, back-to-back
// batches, flush, asynchronous reset and beat_count saturation.
module tb_systolic_input_feeder;

    localparam int ROWS = 4;
    localparam int DW   = 16;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [ROWS*DW-1:0] row_input;
    logic [ROWS-1:0]  row_valid;
    logic [ROWS-1:0]  row_switch;
    logic             busy;
    logic             done;
    logic [15:0]      beat_count;

    int total = 0;
    int bad   = 0;

    systolic_input_feeder_if #(.ROWS(ROWS), .DATA_WIDTH(DW)) s_if ();

    systolic_input_feeder #(
        .ROWS       (ROWS),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .s          (s_if),
        .row_input  (row_input),
        .row_valid  (row_valid),
        .row_switch (row_switch),
        .busy       (busy),
        .done       (done),
        .beat_count (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        s_if.valid  = 1'b0;
        s_if.data   = '0;
        s_if.switch = 1'b0;
        s_if.last   = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic drive_beat(input int base, input logic sw, input logic last);
        s_if.valid  = 1'b1;
        s_if.switch = sw;
        s_if.last   = last;
        for (int r = 0; r < ROWS; r++) s_if.data[r*DW +: DW] = 16'(base + r);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({row_input, row_valid, row_switch, busy, done, beat_count} !== '0) begin
            $display("FAIL reset_outputs: got %0h required 0",
                     {row_input, row_valid, row_switch, busy, done, beat_count});
            bad++;
        end
        rst = 1'b0;
        #1;
        total++;
        if (s_if.ready !== 1'b1) begin
            $display("FAIL reset_ready: got %b required 1", s_if.ready);
            bad++;
        end
    endtask

    task automatic test_single_beat();
        logic [ROWS*DW-1:0] ei;
        logic [ROWS-1:0]    ev;
        s_if.valid  = 1'b1;
        s_if.data   = {16'd4, 16'd3, 16'd2, 16'd1};
        s_if.switch = 1'b1;
        s_if.last   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            drive_idle();
            ei = '0;
            ev = '0;
            if (k < ROWS) begin
                ei[k*DW +: DW] = 16'(k + 1);
                ev[k]          = 1'b1;
            end
            total += 5;
            if (row_input !== ei) begin
                $display("FAIL single_input k=%0d: got %0h required %0h", k, row_input, ei);
                bad++;
            end
            if (row_valid !== ev || row_switch !== ev) begin
                $display("FAIL single_vsw k=%0d: got v=%b sw=%b required %b", k, row_valid,
                         row_switch, ev);
                bad++;
            end
            if (done !== (k == 3)) begin
                $display("FAIL single_done k=%0d: got %b required %b", k, done, k == 3);
                bad++;
            end
            if (s_if.ready !== (k > 2)) begin
                $display("FAIL single_ready k=%0d: got %b required %b", k, s_if.ready, k > 2);
                bad++;
            end
            if (busy !== (k <= 2)) begin
                $display("FAIL single_busy k=%0d: got %b required %b", k, busy, k <= 2);
                bad++;
            end
        end
    endtask

    task automatic test_gap_stream();
        int   base [4] = '{10, 99, 20, 30};
        logic sv   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic ssw  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [ROWS*DW-1:0] ei;
        logic [ROWS-1:0]    ev, es;
        int dones = 0;
        for (int k = 0; k < 9; k++) begin
            drive_idle();
            if (k < 4) begin
                drive_beat(base[k], ssw[k], k == 3);
                s_if.valid = sv[k];
            end
            step();
            ei = '0;
            ev = '0;
            es = '0;
            for (int r = 0; r < ROWS; r++) begin
                if (k - r >= 0 && k - r < 4 && sv[k-r]) begin
                    ei[r*DW +: DW] = 16'(base[k-r] + r);
                    ev[r]          = 1'b1;
                    es[r]          = ssw[k-r];
                end
            end
            if (done === 1'b1) dones++;
            total += 4;
            if (row_input !== ei) begin
                $display("FAIL gap_input k=%0d: got %0h required %0h", k, row_input, ei);
                bad++;
            end
            if (row_valid !== ev) begin
                $display("FAIL gap_valid k=%0d: got %b required %b", k, row_valid, ev);
                bad++;
            end
            if (row_switch !== es) begin
                $display("FAIL gap_switch k=%0d: got %b required %b", k, row_switch, es);
                bad++;
            end
            if (done !== (k == 6)) begin
                $display("FAIL gap_done k=%0d: got %b required %b", k, done, k == 6);
                bad++;
            end
        end
        drive_idle();
        total += 2;
        if (beat_count !== 16'd3) begin
            $display("FAIL gap_count: got %0d required 3", beat_count);
            bad++;
        end
        if (dones !== 1) begin
            $display("FAIL gap_done_pulses: got %0d required 1", dones);
            bad++;
        end
    endtask

    task automatic test_back_to_back();
        int low   = 0;
        int dones = 0;
        for (int k = 0; k < 10; k++) begin
            drive_idle();
            if (k <= 5) drive_beat(k * 10, 1'b0, k >= 1);
            step();
            if (done === 1'b1) dones++;
            if (k >= 1 && k <= 4 && s_if.ready !== 1'b1) low++;
            if (k == 1) begin
                total++;
                if (beat_count !== 16'd2) begin
                    $display("FAIL b2b_count_a: got %0d required 2", beat_count);
                    bad++;
                end
            end
            if (k == 4) begin
                total += 3;
                if (done !== 1'b1) begin
                    $display("FAIL b2b_done_a: got %b required 1", done);
                    bad++;
                end
                if (s_if.ready !== 1'b1) begin
                    $display("FAIL b2b_ready_done_cycle: got %b required 1", s_if.ready);
                    bad++;
                end
                if (beat_count !== 16'd2) begin
                    $display("FAIL b2b_count_hold: got %0d required 2", beat_count);
                    bad++;
                end
            end
            if (k == 5) begin
                total += 3;
                if (beat_count !== 16'd1) begin
                    $display("FAIL b2b_count_b: got %0d required 1", beat_count);
                    bad++;
                end
                if (busy !== 1'b1) begin
                    $display("FAIL b2b_busy_b: got %b required 1", busy);
                    bad++;
                end
                if (row_valid[0] !== 1'b1 || row_input[DW-1:0] !== 16'd50) begin
                    $display("FAIL b2b_row0_b: got v=%b d=%0d required v=1 d=50", row_valid[0],
                             row_input[DW-1:0]);
                    bad++;
                end
            end
            if (k == 8) begin
                total++;
                if (done !== 1'b1) begin
                    $display("FAIL b2b_done_b: got %b required 1", done);
                    bad++;
                end
            end
        end
        drive_idle();
        total += 2;
        if (low !== ROWS - 1) begin
            $display("FAIL b2b_ready_low: got %0d required %0d", low, ROWS - 1);
            bad++;
        end
        if (dones !== 2) begin
            $display("FAIL b2b_done_pulses: got %0d required 2", dones);
            bad++;
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 8; k++) begin
            drive_idle();
            if (k == 0) drive_beat(40, 1'b0, 1'b0);
            if (k == 1) drive_beat(50, 1'b1, 1'b0);
            if (k == 3) begin
                drive_beat(60, 1'b1, 1'b0);
                flush = 1'b1;
                #1;
                total++;
                if (s_if.ready !== 1'b0) begin
                    $display("FAIL flush_ready: got %b required 0", s_if.ready);
                    bad++;
                end
            end
            step();
            if (k == 2) begin
                total += 2;
                if (row_valid !== 4'b0110) begin
                    $display("FAIL flush_pre_valid: got %b required 0110", row_valid);
                    bad++;
                end
                if (busy !== 1'b1 || beat_count !== 16'd2) begin
                    $display("FAIL flush_pre_state: got busy=%b cnt=%0d required busy=1 cnt=2",
                             busy, beat_count);
                    bad++;
                end
            end
            if (k >= 3) begin
                total++;
                if ({row_input, row_valid, row_switch, busy, done, beat_count} !== '0) begin
                    $display("FAIL flush_clear k=%0d: got %0h required 0", k,
                             {row_input, row_valid, row_switch, busy, done, beat_count});
                    bad++;
                end
            end
        end
        drive_idle();
    endtask

    task automatic test_async_reset();
        drive_beat(70, 1'b1, 1'b1);
        step();
        drive_idle();
        step();
        total++;
        if (row_valid !== 4'b0010 || busy !== 1'b1) begin
            $display("FAIL arst_pre: got v=%b busy=%b required v=0010 busy=1", row_valid, busy);
            bad++;
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({row_input, row_valid, row_switch, busy, done, beat_count} !== '0) begin
            $display("FAIL arst_clear: got %0h required 0",
                     {row_input, row_valid, row_switch, busy, done, beat_count});
            bad++;
        end
        #1 rst = 1'b0;
        #1;
        total++;
        if (s_if.ready !== 1'b1) begin
            $display("FAIL arst_ready: got %b required 1", s_if.ready);
            bad++;
        end
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (done !== 1'b0 || row_valid !== '0) begin
                $display("FAIL arst_after k=%0d: got done=%b v=%b required done=0 v=0", k, done,
                         row_valid);
                bad++;
            end
        end
    endtask

    task automatic test_saturation();
        int n      = 70000;
        int dones  = 0;
        int blocked = 0;
        for (int i = 0; i < n; i++) begin
            drive_beat(i & 16'h0fff, 1'b0, i == n - 1);
            if (s_if.ready !== 1'b1) blocked++;
            step();
            if (i < n - 1 && done === 1'b1) dones++;
            if (i + 1 == 65534) begin
                total++;
                if (beat_count !== 16'hFFFE) begin
                    $display("FAIL sat_pre: got %0h required fffe", beat_count);
                    bad++;
                end
            end
        end
        drive_idle();
        total += 3;
        if (beat_count !== 16'hFFFF) begin
            $display("FAIL sat_count: got %0h required ffff", beat_count);
            bad++;
        end
        if (dones !== 0) begin
            $display("FAIL sat_early_done: got %0d required 0", dones);
            bad++;
        end
        if (blocked !== 0) begin
            $display("FAIL sat_stream_ready: got %0d blocked cycles required 0", blocked);
            bad++;
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            if (done === 1'b1) dones++;
            total++;
            if (done !== (k == 3)) begin
                $display("FAIL sat_done k=%0d: got %b required %b", k, done, k == 3);
                bad++;
            end
        end
        total += 2;
        if (dones !== 1) begin
            $display("FAIL sat_done_pulses: got %0d required 1", dones);
            bad++;
        end
        if (beat_count !== 16'hFFFF) begin
            $display("FAIL sat_count_hold: got %0h required ffff", beat_count);
            bad++;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_single_beat();
        test_gap_stream();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
